// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel frame loader: sync byte, FSM encodings
// and the per-pixel colour record.
package pixel_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Byte-stream parser states
   typedef enum logic [1:0] {
      P_HUNT,
      P_COUNT,
      P_DATA,
      P_CHECK
   } parse_state_t;

   // Scan-out (serializer handshake) states
   typedef enum logic [1:0] {
      S_WAIT,
      S_REQ,
      S_ACK,
      S_NEXT
   } scan_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/pixel_bank_ram.sv
// Two banks of NUM_LEDS RGB pixels. One byte-lane write port, one registered
// read port. Contents clear on reset so a reset never displays stale pixels.
module pixel_bank_ram
   import pixel_pkg::*;
#(
   parameter int NUM_LEDS = 10,
   parameter int IDX_W    = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [1:0]       wr_lane,
   input  logic [7:0]       wr_data,
   input  logic             rd_bank,
   input  logic [IDX_W-1:0] rd_idx,
   output rgb_t             rd_data
);

   rgb_t mem [2][NUM_LEDS];

   // Storage: cleared on reset, lane 0/1/2 selects R/G/B of the addressed pixel
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
               mem[b][i] <= '0;
            end
         end
      end else if (wr_en) begin
         case (wr_lane)
            2'd0:    mem[wr_bank][wr_idx].r <= wr_data;
            2'd1:    mem[wr_bank][wr_idx].g <= wr_data;
            2'd2:    mem[wr_bank][wr_idx].b <= wr_data;
            default: ;
         endcase
      end
   end

   // Registered read of the selected bank/pixel
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rd_data <= '0;
      end else begin
         rd_data <= mem[rd_bank][rd_idx];
      end
   end

endmodule

// File: rtl/pixel_frame_loader.sv
// Packet parser, inter-byte timeout, double-buffer commit and periodic
// scan-out of the displayed bank over a valid/busy handshake.
module pixel_frame_loader
   import pixel_pkg::*;
#(
   parameter int NUM_LEDS       = 10,
   parameter int REFRESH_CYCLES = 2097152,
   parameter int TIMEOUT_CYCLES = 120000
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] i_rx_byte,
   input  logic       i_rx_valid,
   input  logic       i_busy,
   output logic       o_valid,
   output logic [7:0] o_red,
   output logic [7:0] o_green,
   output logic [7:0] o_blue,
   output logic       o_frame_done,
   output logic       o_commit,
   output logic       o_err
);

   localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LEDS - 1);
   localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       MAX_COUNT = 8'(NUM_LEDS);

   // Parser state
   parse_state_t     p_state_reg, p_state_next;
   logic [7:0]       cnt_reg, cnt_next;
   logic [IDX_W-1:0] pix_reg, pix_next;
   logic [1:0]       lane_reg, lane_next;
   logic [7:0]       acc_reg, acc_next;
   logic [TMO_W-1:0] tmr_reg, tmr_next;
   logic             commit_reg, commit_next;
   logic             err_reg, err_next;
   logic             set_pend, clr_pend, wr_en;

   // Scan-out state
   scan_state_t      s_state_reg, s_state_next;
   logic [IDX_W-1:0] k_reg, k_next;
   logic [REF_W-1:0] refresh_reg, refresh_next;
   logic             valid_reg, valid_next;
   logic             done_reg, done_next;
   logic             disp_reg, disp_next;
   logic             pending_reg, pending_next;

   rgb_t             rd_data;

   pixel_bank_ram #(
      .NUM_LEDS (NUM_LEDS),
      .IDX_W    (IDX_W)
   ) u_bank (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .wr_en    (wr_en),
      .wr_bank  (~disp_reg),
      .wr_idx   (pix_reg),
      .wr_lane  (lane_reg),
      .wr_data  (i_rx_byte),
      .rd_bank  (disp_reg),
      .rd_idx   (k_reg),
      .rd_data  (rd_data)
   );

   // Parser next-state: timeout has priority over everything except an
   // arriving byte, which always reloads the timer and is never dropped.
   always_comb begin
      p_state_next = p_state_reg;
      cnt_next     = cnt_reg;
      pix_next     = pix_reg;
      lane_next    = lane_reg;
      acc_next     = acc_reg;
      commit_next  = 1'b0;
      err_next     = 1'b0;
      set_pend     = 1'b0;
      clr_pend     = 1'b0;
      wr_en        = 1'b0;
      tmr_next     = (p_state_reg == P_HUNT || i_rx_valid) ? '0 : tmr_reg + 1'b1;
      if (p_state_reg != P_HUNT && !i_rx_valid && tmr_reg == TMO_LAST) begin
         err_next     = 1'b1;
         p_state_next = P_HUNT;
      end else if (i_rx_valid) begin
         case (p_state_reg)
            P_HUNT: begin
               if (i_rx_byte == SYNC_BYTE) p_state_next = P_COUNT;
            end
            P_COUNT: begin
               if (i_rx_byte == 8'd0 || i_rx_byte > MAX_COUNT) begin
                  err_next     = 1'b1;
                  p_state_next = P_HUNT;
               end else begin
                  cnt_next     = i_rx_byte;
                  acc_next     = i_rx_byte;
                  pix_next     = '0;
                  lane_next    = 2'd0;
                  clr_pend     = 1'b1;
                  p_state_next = P_DATA;
               end
            end
            P_DATA: begin
               wr_en    = 1'b1;
               acc_next = acc_reg ^ i_rx_byte;
               if (lane_reg == 2'd2) begin
                  lane_next = 2'd0;
                  if (8'(pix_reg) + 8'd1 == cnt_reg) p_state_next = P_CHECK;
                  else                                pix_next = pix_reg + 1'b1;
               end else begin
                  lane_next = lane_reg + 1'b1;
               end
            end
            P_CHECK: begin
               if (i_rx_byte == acc_reg) begin
                  commit_next = 1'b1;
                  set_pend    = 1'b1;
               end else begin
                  err_next    = 1'b1;
               end
               p_state_next = P_HUNT;
            end
            default: p_state_next = P_HUNT;
         endcase
      end
   end

   // Parser registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         p_state_reg <= P_HUNT;
         cnt_reg     <= '0;
         pix_reg     <= '0;
         lane_reg    <= '0;
         acc_reg     <= '0;
         tmr_reg     <= '0;
         commit_reg  <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         p_state_reg <= p_state_next;
         cnt_reg     <= cnt_next;
         pix_reg     <= pix_next;
         lane_reg    <= lane_next;
         acc_reg     <= acc_next;
         tmr_reg     <= tmr_next;
         commit_reg  <= commit_next;
         err_reg     <= err_next;
      end
   end

   // Scan-out next-state; a commit landing on the refresh expiry cycle is
   // folded in so it swaps immediately.
   always_comb begin
      s_state_next = s_state_reg;
      k_next       = k_reg;
      refresh_next = refresh_reg;
      valid_next   = valid_reg;
      done_next    = 1'b0;
      disp_next    = disp_reg;
      pending_next = (pending_reg | set_pend) & ~clr_pend;
      case (s_state_reg)
         S_WAIT: begin
            if (refresh_reg == REF_LAST) begin
               if (pending_reg | set_pend) begin
                  disp_next    = ~disp_reg;
                  pending_next = 1'b0;
               end
               k_next       = '0;
               refresh_next = '0;
               s_state_next = S_REQ;
            end else begin
               refresh_next = refresh_reg + 1'b1;
            end
         end
         S_REQ: begin
            if (!i_busy) begin
               valid_next   = 1'b1;
               s_state_next = S_ACK;
            end
         end
         S_ACK: begin
            // o_valid doubles as the "busy not yet seen" sub-state
            if (valid_reg) begin
               if (i_busy) valid_next = 1'b0;
            end else if (!i_busy) begin
               s_state_next = S_NEXT;
            end
         end
         S_NEXT: begin
            if (k_reg == LAST_IDX) begin
               done_next    = 1'b1;
               refresh_next = '0;
               s_state_next = S_WAIT;
            end else begin
               k_next       = k_reg + 1'b1;
               s_state_next = S_REQ;
            end
         end
         default: s_state_next = S_WAIT;
      endcase
   end

   // Scan-out, bank select and pending-frame registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s_state_reg <= S_WAIT;
         k_reg       <= '0;
         refresh_reg <= '0;
         valid_reg   <= 1'b0;
         done_reg    <= 1'b0;
         disp_reg    <= 1'b0;
         pending_reg <= 1'b0;
      end else begin
         s_state_reg <= s_state_next;
         k_reg       <= k_next;
         refresh_reg <= refresh_next;
         valid_reg   <= valid_next;
         done_reg    <= done_next;
         disp_reg    <= disp_next;
         pending_reg <= pending_next;
      end
   end

   assign o_valid      = valid_reg;
   assign o_frame_done = done_reg;
   assign o_commit     = commit_reg;
   assign o_err        = err_reg;
   assign o_red        = rd_data.r;
   assign o_green      = rd_data.g;
   assign o_blue       = rd_data.b;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Randomised scoreboard bench for pixel_frame_loader with a busy-holding
// serializer model and a bank/pending reference model.
module tb_pixel_frame_loader;

   localparam int NL       = 10;
   localparam int RC       = 500;
   localparam int TC       = 60;
   localparam int BUSY_CYC = 30;
   localparam int EV_COMMIT = 1;
   localparam int EV_ERR    = 2;
   localparam int PK_GOOD    = 0;
   localparam int PK_BADSUM  = 1;
   localparam int PK_TIMEOUT = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_byte = 8'd0;
   logic       rx_valid = 1'b0;
   logic       busy = 1'b0;
   logic       o_valid, o_frame_done, o_commit, o_err;
   logic [7:0] o_red, o_green, o_blue;

   always #5 clk = ~clk;

   pixel_frame_loader #(
      .NUM_LEDS       (NL),
      .REFRESH_CYCLES (RC),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .CLK          (clk),
      .RST_N        (rst_n),
      .i_rx_byte    (rx_byte),
      .i_rx_valid   (rx_valid),
      .i_busy       (busy),
      .o_valid      (o_valid),
      .o_red        (o_red),
      .o_green      (o_green),
      .o_blue       (o_blue),
      .o_frame_done (o_frame_done),
      .o_commit     (o_commit),
      .o_err        (o_err)
   );

   int checks = 0;
   int fails  = 0;

   // Reference model: two banks, displayed index, pending flag
   logic [7:0] mbank [2][NL][3];
   int         mdisp = 0;
   bit         mpending = 1'b0;
   int         exp_q[$];
   int         frames = 0;
   int         scans  = 0;
   logic [7:0] dir_bytes [6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < NL; i++)
            for (int c = 0; c < 3; c++) mbank[b][i][c] = 8'd0;
      mdisp    = 0;
      mpending = 1'b0;
      exp_q.delete();
   endtask

   // Serializer: takes a request when idle, stays busy for BUSY_CYC cycles
   int bcnt = 0;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         busy = 1'b0;
         bcnt = 0;
      end else if (busy) begin
         if (bcnt > 1) bcnt--;
         else begin
            busy = 1'b0;
            bcnt = 0;
         end
      end else if (o_valid) begin
         busy = 1'b1;
         bcnt = BUSY_CYC;
      end
   end

   // Monitor: pixel colours vs model, colour stability, frame length, events
   int         pix = 0;
   bit         prev_valid = 1'b0, prev_busy = 1'b0, in_xfer = 1'b0, stable = 1'b1;
   logic [23:0] held;
   always @(negedge clk) begin
      if (!rst_n) begin
         pix = 0; prev_valid = 0; prev_busy = 0; in_xfer = 0; stable = 1;
      end else begin
         if (o_valid && !prev_valid) begin
            if (pix == 0) begin
               if (mpending) begin
                  mdisp    = 1 - mdisp;
                  mpending = 1'b0;
               end
               scans++;
            end
            if (pix >= NL) begin
               check("pixel_index", pix, NL - 1);
            end else begin
               check("pixel_colour", {o_red, o_green, o_blue},
                     {mbank[mdisp][pix][0], mbank[mdisp][pix][1], mbank[mdisp][pix][2]});
               $display("pixel %0d frame %0d rgb=%02h%02h%02h", pix, scans, o_red, o_green, o_blue);
            end
            held    = {o_red, o_green, o_blue};
            in_xfer = 1'b1;
            stable  = 1'b1;
            pix++;
         end
         if (in_xfer) begin
            if ({o_red, o_green, o_blue} !== held) stable = 1'b0;
            if (prev_busy && !busy) begin
               check("colour_stable", stable, 1);
               in_xfer = 1'b0;
            end
         end
         if (o_frame_done) begin
            check("pixels_per_frame", pix, NL);
            $display("frame_done after %0d pixels", pix);
            pix = 0;
            frames++;
         end
         if (o_commit || o_err) begin
            if (exp_q.size() == 0) check("unexpected_event", {o_err, o_commit}, 0);
            else check("event", {o_err, o_commit}, exp_q.pop_front());
         end
         prev_valid = o_valid;
         prev_busy  = busy;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic send_packet(input int n, input int kind, input bit directed);
      logic [7:0] acc;
      logic [7:0] b;
      int nbytes;
      send_byte(8'hA5);
      if (n == 0 || n > NL) begin
         exp_q.push_back(EV_ERR);
         send_byte(8'(n));
         $display("packet n=%0d bad count -> err", n);
         return;
      end
      mpending = 1'b0;
      send_byte(8'(n));
      acc    = 8'(n);
      nbytes = (kind == PK_TIMEOUT) ? int'($urandom_range(0, 3 * n - 1)) : 3 * n;
      for (int i = 0; i < nbytes; i++) begin
         b = directed ? dir_bytes[i] : 8'($urandom);
         mbank[1 - mdisp][i / 3][i % 3] = b;
         acc ^= b;
         send_byte(b);
      end
      if (kind == PK_TIMEOUT) begin
         exp_q.push_back(EV_ERR);
         repeat (TC + 1) @(negedge clk);
         $display("packet n=%0d truncated after %0d bytes -> timeout err", n, nbytes);
      end else if (kind == PK_GOOD) begin
         exp_q.push_back(EV_COMMIT);
         mpending = 1'b1;
         send_byte(acc);
         $display("packet n=%0d checksum %02h -> commit", n, acc);
      end else begin
         b = directed ? 8'h00 : (acc ^ 8'($urandom_range(1, 255)));
         exp_q.push_back(EV_ERR);
         send_byte(b);
         $display("packet n=%0d checksum %02h (want %02h) -> err", n, b, acc);
      end
   endtask

   task automatic wait_frame();
      int f0 = frames;
      int n  = 0;
      while (frames == f0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (frames == f0) check("frame_wait", frames, f0 + 1);
   endtask

   task automatic wait_scan();
      int s0 = scans;
      int n  = 0;
      while (scans == s0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (scans == s0) check("scan_wait", scans, s0 + 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_valid"}, o_valid, 0);
      check({tag, "_colour"}, {o_red, o_green, o_blue}, 0);
      check({tag, "_frame_done"}, o_frame_done, 0);
      check({tag, "_commit"}, o_commit, 0);
      check({tag, "_err"}, o_err, 0);
      check({tag, "_all"}, {o_valid, o_frame_done, o_commit, o_err, o_red, o_green, o_blue}, 0);
   endtask

   initial begin
      int kind, n, waited;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      wait_frame();
      // Directed good packet from the test plan
      send_packet(2, PK_GOOD, 1'b1);
      wait_frame();
      // Same packet with a bad checksum: display must stay put
      send_packet(2, PK_BADSUM, 1'b1);
      wait_frame();
      // Bad counts followed by valid packets
      send_packet(0, PK_GOOD, 1'b0);
      send_packet(3, PK_GOOD, 1'b0);
      wait_frame();
      send_packet(NL + 1, PK_GOOD, 1'b0);
      send_packet(NL, PK_GOOD, 1'b0);
      wait_frame();
      // Timeout, then a clean restart
      send_packet(1, PK_TIMEOUT, 1'b0);
      send_packet(4, PK_GOOD, 1'b0);
      wait_frame();
      // Commit during a scan shows only on the following scan
      wait_scan();
      send_packet(5, PK_GOOD, 1'b0);
      wait_frame();
      wait_frame();

      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 1) == 1) wait_scan();
         else wait_frame();
         kind = $urandom_range(0, 3);
         if (kind == 3) n = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(NL + 1, 255));
         else n = $urandom_range(1, NL);
         send_packet(n, (kind == 3) ? PK_GOOD : kind, 1'b0);
      end
      wait_frame();

      // Reset while the parser is mid-DATA and the scan is mid-ACK
      wait_scan();
      send_byte(8'hA5);
      send_byte(8'd5);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      waited = 0;
      while (!busy && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check("busy_before_reset", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_frame();
      send_packet(1, PK_GOOD, 1'b0);
      wait_frame();
      wait_frame();

      check("events_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
